// File: rtl/av2_mem_pkg.sv
// Shared types and helpers for the AV2 frame-buffer AXI4 slave and its SRAM.
package av2_mem_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_DATA  = 2'd2
    } rd_state_e;

    // Per-channel burst bookkeeping latched at the address handshake
    typedef struct packed {
        logic [7:0] len;
        logic [7:0] cnt;
        logic       err;
    } burst_ctx_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/av2_fb_axi_slave_if.sv
// AXI4 (no IDs, no WSTRB) bundle between the frame-buffer master and the frame-buffer slave.
interface av2_fb_axi_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 128
) ();

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
               araddr, arlen, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rlast, rresp, rvalid
    );

    modport slave (
        input  awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
               araddr, arlen, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rlast, rresp, rvalid
    );

endinterface

// File: rtl/av2_fb_sram.sv
// Simple dual-port SRAM: one write port, one registered read port, read-first, no reset.
module av2_fb_sram
    import av2_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned DEPTH      = 4096,
    localparam int unsigned AW        = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Non-blocking update makes a same-cycle read of the written word return old data
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/av2_fb_axi_slave.sv
// AV2 frame-buffer memory as an AXI4 slave with independent write and read channel FSMs.
// Optional burst range checking is enabled by defining AV2_FB_SLV_RANGE_CHK_EN.
module av2_fb_axi_slave
    import av2_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned DEPTH      = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    av2_fb_axi_if.slave s_axi,
    output logic        wlast_err
);

    localparam int unsigned BPW   = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = clog2(BPW);
    localparam int unsigned IDX_W = clog2(DEPTH);

    wr_state_e             wr_state_q;
    burst_ctx_t            wr_ctx_q;
    logic [IDX_W-1:0]      wr_idx_q;
    logic                  awready_q, wready_q, bvalid_q, wlast_err_q;
    logic [1:0]            bresp_q;

    rd_state_e             rd_state_q;
    burst_ctx_t            rd_ctx_q;
    logic [IDX_W-1:0]      rd_idx_q;
    logic                  arready_q, rvalid_q, rlast_q;
    logic [1:0]            rresp_q;

    logic [IDX_W-1:0]      aw_idx_c, ar_idx_c;
    logic                  aw_err_c, ar_err_c;
    logic                  wr_last_c, sram_we_c, sram_re_c;
    logic [DATA_WIDTH-1:0] sram_rdata;
    logic                  unused_c;

    assign aw_idx_c = s_axi.awaddr[OFF_W +: IDX_W];
    assign ar_idx_c = s_axi.araddr[OFF_W +: IDX_W];

`ifdef AV2_FB_SLV_RANGE_CHK_EN
    localparam int unsigned EW = IDX_W + 9;
    // Error if upper address bits are set or the burst runs past the last word
    assign aw_err_c = (s_axi.awaddr[ADDR_WIDTH-1:OFF_W+IDX_W] != '0) ||
                      ((EW'(aw_idx_c) + EW'(s_axi.awlen)) > EW'(DEPTH - 1));
    assign ar_err_c = (s_axi.araddr[ADDR_WIDTH-1:OFF_W+IDX_W] != '0) ||
                      ((EW'(ar_idx_c) + EW'(s_axi.arlen)) > EW'(DEPTH - 1));
    assign unused_c = ^{s_axi.awaddr[OFF_W-1:0], s_axi.araddr[OFF_W-1:0]};
`else
    assign aw_err_c = 1'b0;
    assign ar_err_c = 1'b0;
    assign unused_c = ^{s_axi.awaddr[ADDR_WIDTH-1:OFF_W+IDX_W], s_axi.awaddr[OFF_W-1:0],
                        s_axi.araddr[ADDR_WIDTH-1:OFF_W+IDX_W], s_axi.araddr[OFF_W-1:0]};
`endif

    assign wr_last_c = (wr_ctx_q.cnt == wr_ctx_q.len);
    assign sram_we_c = (wr_state_q == WR_DATA) && s_axi.wvalid && !wr_ctx_q.err;
    assign sram_re_c = (rd_state_q == RD_FETCH) && !rd_ctx_q.err;

    // Write channel: AW -> data beats -> single B response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q  <= WR_IDLE;
            wr_ctx_q    <= '0;
            wr_idx_q    <= '0;
            awready_q   <= 1'b1;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= AXI_RESP_OKAY;
            wlast_err_q <= 1'b0;
        end else begin
            wlast_err_q <= 1'b0;
            case (wr_state_q)
                WR_IDLE: begin
                    if (s_axi.awvalid) begin
                        wr_idx_q     <= aw_idx_c;
                        wr_ctx_q.len <= s_axi.awlen;
                        wr_ctx_q.cnt <= 8'd0;
                        wr_ctx_q.err <= aw_err_c;
                        awready_q    <= 1'b0;
                        wready_q     <= 1'b1;
                        wr_state_q   <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (s_axi.wvalid) begin
                        wr_idx_q     <= wr_idx_q + IDX_W'(1);
                        wr_ctx_q.cnt <= wr_ctx_q.cnt + 8'd1;
                        wlast_err_q  <= (s_axi.wlast != wr_last_c);
                        if (wr_last_c) begin
                            wready_q   <= 1'b0;
                            bvalid_q   <= 1'b1;
                            bresp_q    <= wr_ctx_q.err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                            wr_state_q <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (s_axi.bready) begin
                        bvalid_q   <= 1'b0;
                        bresp_q    <= AXI_RESP_OKAY;
                        awready_q  <= 1'b1;
                        wr_state_q <= WR_IDLE;
                    end
                end
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end

    // Read channel: AR -> (fetch -> data) per beat, one beat per two cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= RD_IDLE;
            rd_ctx_q   <= '0;
            rd_idx_q   <= '0;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rresp_q    <= AXI_RESP_OKAY;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    if (s_axi.arvalid) begin
                        rd_idx_q     <= ar_idx_c;
                        rd_ctx_q.len <= s_axi.arlen;
                        rd_ctx_q.cnt <= 8'd0;
                        rd_ctx_q.err <= ar_err_c;
                        arready_q    <= 1'b0;
                        rd_state_q   <= RD_FETCH;
                    end
                end
                RD_FETCH: begin
                    rvalid_q   <= 1'b1;
                    rlast_q    <= (rd_ctx_q.cnt == rd_ctx_q.len);
                    rresp_q    <= rd_ctx_q.err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    rd_state_q <= RD_DATA;
                end
                RD_DATA: begin
                    if (s_axi.rready) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        rresp_q  <= AXI_RESP_OKAY;
                        if (rlast_q) begin
                            arready_q  <= 1'b1;
                            rd_state_q <= RD_IDLE;
                        end else begin
                            rd_idx_q     <= rd_idx_q + IDX_W'(1);
                            rd_ctx_q.cnt <= rd_ctx_q.cnt + 8'd1;
                            rd_state_q   <= RD_FETCH;
                        end
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    av2_fb_sram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_sram (
        .clk     (clk),
        .we_i    (sram_we_c),
        .waddr_i (wr_idx_q),
        .wdata_i (s_axi.wdata),
        .re_i    (sram_re_c),
        .raddr_i (rd_idx_q),
        .rdata_o (sram_rdata)
    );

    // SRAM output is unreset, so gate it to keep rdata at zero outside valid beats
    assign s_axi.rdata   = (rvalid_q && !rd_ctx_q.err) ? sram_rdata : '0;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign wlast_err     = wlast_err_q;

endmodule

// File: tb/tb_av2_fb_axi_slave.sv
// Directed scoreboard bench for av2_fb_axi_slave (DEPTH=16, 128-bit data).
module tb_av2_fb_axi_slave;

    logic clk;
    logic rst_n;
    logic wlast_err;

    av2_fb_axi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) bus ();

    av2_fb_axi_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (128),
        .DEPTH      (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_axi     (bus),
        .wlast_err (wlast_err)
    );

    typedef struct {
        logic [127:0] d;
        logic         last;
        logic [1:0]   resp;
    } rexp_t;

    rexp_t        sb[$];
    logic [127:0] model [16];
    int           total = 0;
    int           bad = 0;
    int           werr_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (wlast_err === 1'b1) werr_cnt++;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig_of(input int which);
        case (which)
            0: return bus.awready;
            1: return bus.wready;
            2: return bus.bvalid;
            3: return bus.arready;
            4: return bus.rvalid;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_hi(input int which, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (sig_of(which) !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sig_of(which) !== 1'b1) check({tag, "_timeout"}, 128'(sig_of(which)), 128'd1);
    endtask

    function automatic logic burst_err(input logic [31:0] addr, input logic [7:0] len);
`ifdef AV2_FB_SLV_RANGE_CHK_EN
        return (addr[31:8] != 24'd0) || ((32'(addr[7:4]) + 32'(len)) > 32'd15);
`else
        return 1'b0 & (^{addr, len});
`endif
    endfunction

    task automatic aw_send(input logic [31:0] addr, input logic [7:0] len);
        bus.awaddr  = addr;
        bus.awlen   = len;
        bus.awvalid = 1'b1;
        wait_hi(0, "awready");
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [127:0] data, input logic last);
        bus.wdata  = data;
        bus.wlast  = last;
        bus.wvalid = 1'b1;
        wait_hi(1, "wready");
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
    endtask

    // Full write burst; early_mask forces wlast on earlier beats
    task automatic w_burst(input logic [31:0] addr, input logic [7:0] len, input logic [7:0] early_mask);
        logic         err;
        logic [3:0]   idx;
        logic [127:0] d;
        err = burst_err(addr, len);
        idx = addr[7:4];
        aw_send(addr, len);
        for (int i = 0; i <= int'(len); i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            w_beat(d, (i == int'(len)) || (i < 8 && early_mask[i]));
            if (!err) model[idx] = d;
            idx = idx + 4'd1;
        end
    endtask

    task automatic b_check(input logic [1:0] exp_resp, input string tag);
        bus.bready = 1'b1;
        wait_hi(2, {tag, "_bvalid"});
        check({tag, "_bresp"}, 128'(bus.bresp), 128'(exp_resp));
        @(posedge clk); #1;
        bus.bready = 1'b0;
        @(negedge clk);
        check({tag, "_single_b"}, 128'(bus.bvalid), 128'd0);
        @(posedge clk); #1;
    endtask

    task automatic ar_send(input logic [31:0] addr, input logic [7:0] len);
        logic  err;
        logic [3:0] idx;
        rexp_t e;
        err = burst_err(addr, len);
        idx = addr[7:4];
        for (int i = 0; i <= int'(len); i++) begin
            e.d    = err ? 128'd0 : model[idx];
            e.last = (i == int'(len));
            e.resp = err ? 2'b10 : 2'b00;
            sb.push_back(e);
            idx = idx + 4'd1;
        end
        bus.araddr  = addr;
        bus.arlen   = len;
        bus.arvalid = 1'b1;
        wait_hi(3, "arready");
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
    endtask

    task automatic r_collect(input int n, input int stall, input string tag);
        rexp_t e;
        for (int b = 0; b < n; b++) begin
            wait_hi(4, {tag, "_rvalid"});
            if (sb.size() == 0) begin
                check({tag, "_sb_empty"}, 128'd1, 128'd0);
                return;
            end
            e = sb[0];
            for (int s = 0; s < stall; s++) begin
                check({tag, "_hold_data"}, bus.rdata, e.d);
                check({tag, "_hold_last"}, 128'(bus.rlast), 128'(e.last));
                @(negedge clk);
            end
            bus.rready = 1'b1;
            check({tag, "_rdata"}, bus.rdata, e.d);
            check({tag, "_rlast"}, 128'(bus.rlast), 128'(e.last));
            check({tag, "_rresp"}, 128'(bus.rresp), 128'(e.resp));
            void'(sb.pop_front());
            @(posedge clk); #1;
            bus.rready = 1'b0;
        end
    endtask

    initial begin
        int    w0;
        rexp_t e;
        logic [127:0] da, db;

        rst_n = 1'b0;
        bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_awready", 128'(bus.awready), 128'd1);
        check("rst_arready", 128'(bus.arready), 128'd1);
        check("rst_wready",  128'(bus.wready),  128'd0);
        check("rst_bvalid",  128'(bus.bvalid),  128'd0);
        check("rst_bresp",   128'(bus.bresp),   128'd0);
        check("rst_rvalid",  128'(bus.rvalid),  128'd0);
        check("rst_rdata",   bus.rdata,         128'd0);
        check("rst_rlast",   128'(bus.rlast),   128'd0);
        check("rst_rresp",   128'(bus.rresp),   128'd0);
        check("rst_wlasterr", 128'(wlast_err),  128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill the whole memory so every later read has a defined expectation
        w_burst(32'h0000_0000, 8'd15, 8'h00);
        b_check(2'b00, "fill");

        // Basic burst and first-beat latency
        w0 = werr_cnt;
        w_burst(32'h0000_0020, 8'd3, 8'h00);
        b_check(2'b00, "t1w");
        check("t1_no_wlast_err", 128'(werr_cnt - w0), 128'd0);
        ar_send(32'h0000_0020, 8'd3);
        @(negedge clk);
        check("t1_lat_c1", 128'(bus.rvalid), 128'd0);
        @(negedge clk);
        check("t1_lat_c2", 128'(bus.rvalid), 128'd1);
        @(posedge clk); #1;
        r_collect(4, 0, "t1r");

        // Back-pressured read: outputs held, exactly two beats
        ar_send(32'h0000_0020, 8'd1);
        r_collect(2, 5, "t2r");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_no_extra_beat", 128'(bus.rvalid), 128'd0);
        end
        check("t2_sb_drained", 128'(sb.size()), 128'd0);
        @(posedge clk); #1;

        // Early wlast
        w0 = werr_cnt;
        w_burst(32'h0000_0030, 8'd2, 8'h02);
        b_check(2'b00, "t3w");
        check("t3_wlast_err_once", 128'(werr_cnt - w0), 128'd1);
        ar_send(32'h0000_0030, 8'd2);
        r_collect(3, 0, "t3r");

        // Burst wrapping past the last word
        w_burst(32'h0000_00F0, 8'd1, 8'h00);
`ifdef AV2_FB_SLV_RANGE_CHK_EN
        b_check(2'b10, "t4w");
`else
        b_check(2'b00, "t4w");
`endif
        ar_send(32'h0000_00F0, 8'd1);
        r_collect(2, 0, "t4r");
        ar_send(32'h0000_0000, 8'd0);
        r_collect(1, 0, "t4r0");

        // Same-cycle read and write of word 5 is read-first
        da = {4{32'hAAAA_0005}};
        db = {4{32'hBBBB_0005}};
        aw_send(32'h0000_0050, 8'd0);
        w_beat(da, 1'b1);
        model[5] = da;
        b_check(2'b00, "t5a");
        aw_send(32'h0000_0050, 8'd0);
        ar_send(32'h0000_0050, 8'd0);
        bus.wdata  = db;
        bus.wlast  = 1'b1;
        bus.wvalid = 1'b1;
        @(negedge clk);
        check("t5_wready_collide", 128'(bus.wready), 128'd1);
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        model[5] = db;
        r_collect(1, 0, "t5old");
        b_check(2'b00, "t5b");
        ar_send(32'h0000_0050, 8'd0);
        r_collect(1, 0, "t5new");

        // Reset in the middle of a read burst
        ar_send(32'h0000_0000, 8'd3);
        r_collect(2, 0, "t6pre");
        wait_hi(4, "t6_beat2");
        rst_n = 1'b0;
        #1;
        check("t6_rvalid_rst", 128'(bus.rvalid), 128'd0);
        check("t6_arready_rst", 128'(bus.arready), 128'd1);
        check("t6_rlast_rst", 128'(bus.rlast), 128'd0);
        sb.delete();
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        ar_send(32'h0000_0040, 8'd3);
        r_collect(4, 0, "t6post");
        check("t6_sb_drained", 128'(sb.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
